// File: rtl/mac_fix_pipe.sv
// mac_fix_pipe: pipelined signed fixed-point multiply-accumulate with valid/ready streaming
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_a/in_b/in_last element stream;
//        out_valid/out_ready/out_data/out_sat rescaled dot-product result.
// Optional saturation of the rescaled sum is enabled by defining MAC_FIX_SAT_EN;
// without it the low W bits wrap and out_sat stays 0.
module mac_fix_pipe #(
  parameter int W       = 8,
  parameter int FRAC    = 7,
  parameter int MAX_LEN = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_a,
  input  logic signed [W-1:0] in_b,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_sat
);
  localparam int ACC_W = 2*W + $clog2(MAX_LEN);
  localparam int CW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  logic                    stall, v1, l1, last, load, res_sat;
  logic signed [2*W-1:0]   p1;
  logic signed [ACC_W-1:0] acc, sum;
  logic [CW-1:0]           cnt;
  logic signed [W-1:0]     res;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall & ~rst;
  // the MAX_LEN-th element closes the vector even without in_last
  assign last     = l1 | (cnt == CW'(MAX_LEN-1));
  assign load     = v1 & ~stall & last;
  assign sum      = acc + {{(ACC_W-2*W){p1[2*W-1]}}, p1};
`ifdef MAC_FIX_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};
  logic signed [ACC_W-1:0] shifted;
  assign shifted = sum >>> FRAC;
  assign res_sat = (shifted > MAXV) | (shifted < MINV);
  assign res     = shifted > MAXV ? MAXV[W-1:0] : shifted < MINV ? MINV[W-1:0] : shifted[W-1:0];
`else
  assign res_sat = 1'b0;
  assign res     = W'(sum >>> FRAC);
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      p1        <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (!stall) begin
        v1 <= in_valid;
        if (in_valid) begin
          p1 <= in_a * in_b;
          l1 <= in_last;
        end
        if (v1) begin
          acc <= last ? '0 : sum;
          cnt <= last ? '0 : cnt + CW'(1);
        end
      end
      // a fresh result may load in the same cycle the previous one is taken
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= res;
        out_sat   <= res_sat;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_fix_pipe.sv
// tb_mac_fix_pipe: self-checking bench for mac_fix_pipe
module tb_mac_fix_pipe;
  localparam int W = 8, FRAC = 7, MAX_LEN = 1024;
  logic clk = 0, rst = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic signed [W-1:0] in_a = 0, in_b = 0;
  logic in_ready, out_valid, out_sat;
  logic signed [W-1:0] out_data;
  mac_fix_pipe #(.W(W), .FRAC(FRAC), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sat(out_sat)
  );
  always #5 clk = ~clk;
  typedef struct packed { logic signed [7:0] d; logic s; } res_t;
  typedef struct packed { logic [2:0] n; logic [31:0] a; logic [31:0] b; logic [7:0] d; logic s; } vec_t;
  res_t   exp_q[$];
  res_t   ovr;
  logic   ovr_en = 0;
  longint acc_m = 0;
  int     cnt_m = 0;
  int     npass = 0, nchk = 0;
  logic   s_ov, s_ir;
  vec_t   tab[8];
  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  function automatic res_t model(input longint s);
    longint sh;
    longint hi;
    res_t r;
    sh = s >>> FRAC;
    hi = (longint'(1) <<< (W-1)) - 1;
`ifdef MAC_FIX_SAT_EN
    r.s = (sh > hi) || (sh < -hi-1);
    r.d = sh > hi ? 8'(hi) : sh < -hi-1 ? 8'(-hi-1) : 8'(sh);
`else
    r.s = 1'b0;
    r.d = 8'(sh);
`endif
    return r;
  endfunction
  task automatic step(input logic v, input logic signed [7:0] a, input logic signed [7:0] b,
                      input logic l, input logic r);
    res_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_b = b; in_last = l; out_ready = r;
    #1;
    s_ov = out_valid;
    s_ir = in_ready;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("out_unexpected_valid", out_valid, 0);
      else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, $signed(e.d));
        chk("out_sat", out_sat, e.s);
      end
    end
    if (v && in_ready) begin
      acc_m += longint'(a) * longint'(b);
      cnt_m++;
      if (l || cnt_m == MAX_LEN) begin
        exp_q.push_back(ovr_en ? ovr : model(acc_m));
        acc_m = 0;
        cnt_m = 0;
      end
    end
  endtask
  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(0, 0, 0, 0, 1);
    chk("drain_pending", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_last = 0; out_ready = 0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 0;
    acc_m = 0; cnt_m = 0; exp_q.delete();
    #1;
    chk("post_rst_in_ready", in_ready, 1);
  endtask
  function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                              input logic [7:0] d, input logic s);
    vec_t t;
    t.n = 3'(n); t.a = a; t.b = b; t.d = d; t.s = s;
    return t;
  endfunction
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic signed [7:0] held;
    tab[0] = mk(1, {24'd0, 8'sd64}, {24'd0, 8'sd64}, 8'sd32, 0);
    tab[1] = mk(2, {16'd0, 8'sd64, 8'sd64}, {16'd0, 8'sd64, 8'sd64}, 8'sd64, 0);
    tab[2] = mk(1, {24'd0, -8'sd128}, {24'd0, 8'sd127}, -8'sd127, 0);
`ifdef MAC_FIX_SAT_EN
    tab[3] = mk(4, {4{8'sd127}}, {4{8'sd127}}, 8'sd127, 1);
    tab[4] = mk(1, {24'd0, -8'sd128}, {24'd0, -8'sd128}, 8'sd127, 1);
    tab[5] = mk(3, {8'd0, {3{-8'sd128}}}, {8'd0, {3{8'sd127}}}, -8'sd128, 1);
`else
    tab[3] = mk(4, {4{8'sd127}}, {4{8'sd127}}, -8'sd8, 0);
    tab[4] = mk(1, {24'd0, -8'sd128}, {24'd0, -8'sd128}, -8'sd128, 0);
    tab[5] = mk(3, {8'd0, {3{-8'sd128}}}, {8'd0, {3{8'sd127}}}, -8'sd125, 0);
`endif
    tab[6] = mk(1, {24'd0, 8'sd1}, {24'd0, -8'sd1}, -8'sd1, 0);
    tab[7] = mk(2, {16'd0, -8'sd5, 8'sd3}, {16'd0, 8'sd2, 8'sd7}, 8'sd0, 0);
    do_reset();
    // latency: accept in cycle t, out_valid visible at t+2
    step(1, 64, 64, 1, 1);
    step(0, 0, 0, 0, 1);
    chk("latency_t1_out_valid", s_ov, 0);
    step(0, 0, 0, 0, 1);
    chk("latency_t2_out_valid", s_ov, 1);
    drain();
    // table vectors, issued back to back at full rate
    for (int i = 0; i < 8; i++) begin
      ovr_en = 1;
      ovr.d = tab[i].d;
      ovr.s = tab[i].s;
      for (int k = 0; k < int'(tab[i].n); k++)
        step(1, tab[i].a[8*k+:8], tab[i].b[8*k+:8], k == int'(tab[i].n) - 1, 1);
    end
    ovr_en = 0;
    drain();
    // backpressure: result held while out_ready low, input blocked
    step(1, 64, 64, 1, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("stall_out_valid", s_ov, 1);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom), 8'($urandom), 1, 0);
      chk("stall_in_ready", s_ir, 0);
      chk("stall_out_data_stable", out_data, held);
    end
    drain();
    // reset in the middle of a vector drops it
    step(1, 100, 100, 0, 1);
    step(1, 100, 100, 0, 1);
    step(1, 100, 100, 0, 1);
    do_reset();
    step(1, 64, 64, 1, 1);
    drain();
    // MAX_LEN elements without in_last close the vector on their own
    for (int i = 0; i < MAX_LEN; i++) step(1, 1, 1, 0, 1);
    step(1, 64, 64, 1, 1);
    drain();
    // randomized traffic with gaps and backpressure
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 9) < 7);
    for (int i = 0; i < 40 && !s_ir; i++) step(0, 0, 0, 0, 1);
    step(1, 8'($urandom), 8'($urandom), 1, 1);
    drain();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
